lns_to_lin: RTL and testbench
=============================

Name: lns_to_lin

Overview:
- Decodes one accumulated logarithmic-number-system (LNS) result into a signed linear fixed-point value.
- Sits downstream of the log-domain MAC and consumes its result port and natural-sign bit, using the same valid/enable handshake.
- Computes 2^(fractional part) iteratively, one fractional bit per cycle, using a constant ROM, then scales by the integer part, saturates and applies the sign.

Parameters:
- LOG_BITS, 16, MSB index of the signed LNS input; the input is LOG_BITS+1 bits wide.
- FRAC_BITS, 8, number of fractional bits in the LNS value. This equals the number of iteration cycles.
- MANT_FRAC, 16, fractional bits of the internal mantissa register (Q2.MANT_FRAC).
- LIN_BITS, 31, MSB index of the signed linear output; the output is LIN_BITS+1 bits wide.
- LIN_FRAC, 8, fractional bits of the linear output.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- data_in_valid  in  1  an LNS word is presented.
- data_in_log  in  LOG_BITS+1  signed two's-complement log2 value, with FRAC_BITS fractional bits.
- data_in_nat_sign  in  1  natural sign: 1 = positive, 0 = negative.
- data_in_enable  out  1  block can accept an input this cycle.
- data_out_enable  in  1  downstream accepts the output this cycle.
- data_out_valid  out  1  data_out_lin holds a result.
- data_out_lin  out  LIN_BITS+1  signed linear result, with LIN_FRAC fractional bits.
- data_out_sat  out  1  result was clamped by overflow.

Behaviour:
- Reset: async on rst high.
  - state = IDLE.
  - data_out_valid = 0, data_out_lin = 0, data_out_sat = 0.
  - All internal registers are 0.
- FSM states: IDLE, EXP, SCALE, OUT.
- data_in_enable = (state==IDLE) | (state==OUT & data_out_enable).
  - An input is accepted on any edge where data_in_valid & data_in_enable.
- Capture on accept:
  - int = data_in_log >>> FRAC_BITS (arithmetic shift).
  - f = data_in_log[FRAC_BITS-1:0].
  - sign and zero flag are registered; zero flag = (data_in_log == most-negative value).
  - mant = 1.0, i.e. 1<<MANT_FRAC.
  - iteration counter k = 1.
  - Next state = EXP.
- EXP: one iteration per edge, for k = 1..FRAC_BITS.
  - If f[FRAC_BITS-k] = 1: mant = (mant * C_k) >> MANT_FRAC, truncated.
  - C_k = round(2^(2^-k) * 2^MANT_FRAC) is a constant ROM; C_1 = 92682 for MANT_FRAC=16.
  - The multiplier width must be sufficient for no intermediate overflow; mant stays in [1.0, 2.0).
  - After k = FRAC_BITS, next state = SCALE.
- SCALE: one edge.
  - sh = int + LIN_FRAC - MANT_FRAC.
  - sh >= 0: mag = mant << sh. sh < 0: mag = mant >> -sh, truncated toward zero; shifts of MANT_FRAC+2 or more give 0.
  - If mag > 2^LIN_BITS - 1: mag = 2^LIN_BITS - 1 and sat = 1. This overflow check must not wrap for large int.
  - If the zero flag is set: mag = 0, sat = 0.
  - data_out_lin = sign ? mag : -mag.
  - data_out_valid is set and next state = OUT.
- Latency: accept at edge E0 gives data_out_valid high after edge E0+FRAC_BITS+1, which is 9 for the defaults.
  - Latency is fixed and independent of data, including the zero input.
- OUT: hold data_out_lin, data_out_sat and data_out_valid stable until data_out_enable.
  - data_out_enable & data_in_valid: accept the new word on the same edge, clear data_out_valid and go to EXP. There is no bubble in accepting.
  - data_out_enable without data_in_valid: clear data_out_valid and go to IDLE.
- data_out_enable while not in OUT is ignored.
- data_in_valid while data_in_enable = 0 is ignored. Upstream must hold its data, as the MAC does.
- Reset mid-EXP or mid-OUT: the in-flight result is discarded and outputs return to reset values immediately.
- The output is never -2^LIN_BITS; the negative magnitude is clamped symmetrically.

Test Plan:
- Defaults; log = 0, sign = 1 -> after 9 cycles data_out_lin = 256 (1.0), sat = 0.
- log = 768 (3.0), sign = 1 -> 2048. log = -256 (-1.0), sign = 0 -> -128.
- log = 128 (0.5), sign = 1 -> 362 (sqrt 2), tolerance ±1 LSB. log = 0x00FF -> 510 ±1.
- Extremes:
  - log = 10240 (2^40) -> 2147483647, sat = 1.
  - log = 10240, sign = 0 -> -2147483647, sat = 1.
  - log = -5120 (2^-20) -> 0, sat = 0.
  - log = -65536 (zero code) -> 0.
- Back-to-back with backpressure:
  - Hold data_out_enable = 0 for 5 cycles -> output stable and data_in_enable = 0.
  - Then assert data_out_enable with the next word valid -> accepted on the same edge; the next result appears 9 edges later.
- Assert rst for 1 cycle during EXP -> data_out_valid = 0 and state IDLE immediately; the next accepted word decodes correctly.

Source files
------------

// File: rtl/lns_to_lin.sv
// LNS-to-linear decoder: iterative 2^frac (one fractional bit per cycle via a
// constant ROM of 2^(2^-k)), then integer scaling, saturation and sign.
`timescale 1ns/1ps
module lns_to_lin #(
    parameter int LOG_BITS  = 16,
    parameter int FRAC_BITS = 8,
    parameter int MANT_FRAC = 16,
    parameter int LIN_BITS  = 31,
    parameter int LIN_FRAC  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_in_valid,
    input  logic [LOG_BITS:0]   data_in_log,
    input  logic                data_in_nat_sign,
    output logic                data_in_enable,
    input  logic                data_out_enable,
    output logic                data_out_valid,
    output logic [LIN_BITS:0]   data_out_lin,
    output logic                data_out_sat
);
    localparam int MW = MANT_FRAC + 2;
    localparam int IW = LOG_BITS - FRAC_BITS + 1;
    localparam int KW = $clog2(FRAC_BITS + 1);
    localparam int WW = MW + LIN_BITS;

    typedef enum logic [1:0] {IDLE, EXP, SCALE, OUT} state_t;

    function automatic logic [63:0] isqrt64(input logic [63:0] x);
        logic [63:0] rem, res, bit_v;
        rem   = x;
        res   = '0;
        bit_v = 64'd1 << 62;
        for (int i = 0; i < 32; i++) begin
            if (rem >= res + bit_v) begin
                rem = rem - (res + bit_v);
                res = (res >> 1) + bit_v;
            end else begin
                res = res >> 1;
            end
            bit_v = bit_v >> 2;
        end
        return res;
    endfunction

    // 2^(2^-k) by k repeated square roots of 2.0 held with 30 fraction bits,
    // then rounded to MANT_FRAC bits.
    function automatic logic [MW-1:0] calc_c(input int k);
        logic [63:0] x;
        x = 64'd1 << 31;
        for (int j = 0; j < k; j++) x = isqrt64(x << 30);
        return MW'((x + (64'd1 << (29 - MANT_FRAC))) >> (30 - MANT_FRAC));
    endfunction

    logic [FRAC_BITS:0][MW-1:0] w_rom;
    assign w_rom[0] = MW'(1) << MANT_FRAC;
    for (genvar g = 1; g <= FRAC_BITS; g++) begin : g_rom
        localparam logic [MW-1:0] C_K = calc_c(g);
        assign w_rom[g] = C_K;
    end

    state_t                r_state;
    logic signed [IW-1:0]  r_int;
    logic [FRAC_BITS-1:0]  r_f;
    logic                  r_sign;
    logic                  r_zero;
    logic [MW-1:0]         r_mant;
    logic [KW-1:0]         r_k;

    logic                  w_accept;
    logic [2*MW-1:0]       w_prod;
    logic [MW-1:0]         w_mant_next;
    int                    w_sh;
    logic [WW-1:0]         w_wide;
    logic                  w_ovf;
    logic [LIN_BITS-1:0]   w_mag;

    assign data_in_enable = (r_state == IDLE) | ((r_state == OUT) & data_out_enable);
    assign w_accept       = data_in_valid & data_in_enable;

    assign w_prod      = {{MW{1'b0}}, r_mant} * {{MW{1'b0}}, w_rom[r_k]};
    assign w_mant_next = MW'(w_prod >> MANT_FRAC);

    // Shift into a window wide enough to see every overflowing bit; shifts
    // beyond the window are decided directly so large exponents cannot wrap.
    always_comb begin
        w_sh   = int'(r_int) + LIN_FRAC - MANT_FRAC;
        w_wide = '0;
        w_ovf  = 1'b0;
        if (w_sh >= LIN_BITS)
            w_ovf = 1'b1;
        else if (w_sh >= 0)
            w_wide = {{LIN_BITS{1'b0}}, r_mant} << w_sh;
        else if (-w_sh < MW)
            w_wide = {{LIN_BITS{1'b0}}, r_mant} >> (-w_sh);
        if (w_wide[WW-1:LIN_BITS] != '0)
            w_ovf = 1'b1;
        w_mag = w_ovf ? {LIN_BITS{1'b1}} : w_wide[LIN_BITS-1:0];
        if (r_zero) begin
            w_mag = '0;
            w_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_int          <= '0;
            r_f            <= '0;
            r_sign         <= 1'b0;
            r_zero         <= 1'b0;
            r_mant         <= '0;
            r_k            <= '0;
            data_out_valid <= 1'b0;
            data_out_lin   <= '0;
            data_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: ;
                EXP: begin
                    if (r_f[FRAC_BITS-1])
                        r_mant <= w_mant_next;
                    r_f <= r_f << 1;
                    r_k <= r_k + 1'b1;
                    if (r_k == KW'(FRAC_BITS))
                        r_state <= SCALE;
                end
                SCALE: begin
                    data_out_lin   <= r_sign ? {1'b0, w_mag} : -{1'b0, w_mag};
                    data_out_sat   <= w_ovf;
                    data_out_valid <= 1'b1;
                    r_state        <= OUT;
                end
                OUT: begin
                    if (data_out_enable) begin
                        data_out_valid <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Acceptance overrides the OUT->IDLE exit so a waiting word starts without a bubble.
            if (w_accept) begin
                r_int   <= data_in_log[LOG_BITS:FRAC_BITS];
                r_f     <= data_in_log[FRAC_BITS-1:0];
                r_sign  <= data_in_nat_sign;
                r_zero  <= (data_in_log == {1'b1, {LOG_BITS{1'b0}}});
                r_mant  <= MW'(1) << MANT_FRAC;
                r_k     <= KW'(1);
                r_state <= EXP;
            end
        end
    end
endmodule

// File: tb/tb_lns_to_lin.sv
// Scoreboard bench for lns_to_lin: driver pushes model results on accept,
// a negedge monitor pops and compares whenever a result is handed off.
`timescale 1ns/1ps
module tb_lns_to_lin;
    localparam int     LAT  = 9;
    localparam longint MAXM = 64'h7FFF_FFFF;
    localparam int     ND   = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_in_valid = 1'b0;
    logic [16:0] data_in_log = '0;
    logic        data_in_nat_sign = 1'b0;
    logic        data_in_enable;
    logic        data_out_enable = 1'b0;
    logic        data_out_valid;
    logic [31:0] data_out_lin;
    logic        data_out_sat;

    typedef struct {
        logic [31:0] lin;
        bit          sat;
        int          acc;
        bit          hg;
        longint      gold;
        int          tol;
        logic [16:0] lg;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0, n_chk = 0, n_bad = 0, cyc = 0;
    bit   oe_force = 1'b0, oe_val = 1'b1;
    bit   prev_valid = 1'b0, prev_oe = 1'b0, prev_sat = 1'b0;
    logic [31:0] prev_lin = '0;
    exp_t   mon_e;
    longint mon_d;

    logic [16:0] d_lg  [ND] = '{17'h00000, 17'h00300, 17'h1FF00, 17'h00080, 17'h000FF,
                                17'h02800, 17'h02800, 17'h1EC00, 17'h10000, 17'h10000, 17'h0FFFF};
    bit          d_sg  [ND] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 1};
    longint      d_gold[ND] = '{256, 2048, -128, 362, 510, 2147483647, -2147483647, 0, 0, 0, 2147483647};
    int          d_tol [ND] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};

    lns_to_lin dut (
        .clk             (clk),
        .rst             (rst),
        .data_in_valid   (data_in_valid),
        .data_in_log     (data_in_log),
        .data_in_nat_sign(data_in_nat_sign),
        .data_in_enable  (data_in_enable),
        .data_out_enable (data_out_enable),
        .data_out_valid  (data_out_valid),
        .data_out_lin    (data_out_lin),
        .data_out_sat    (data_out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint ck(input int k);
        return longint'($rtoi($pow(2.0, 1.0 / real'(1 << k)) * 65536.0 + 0.5));
    endfunction

    // Reference decode: 2^(f/256) as a product of rounded 2^(2^-k) constants
    // with truncation after each product, then scale by 2^int and clamp.
    function automatic void model(input logic [16:0] lg, input bit sgn,
                                  output logic [31:0] lin, output bit sat);
        int ip, f, sh;
        longint m, mag;
        ip  = int'($signed(lg)) >>> 8;
        f   = int'(lg[7:0]);
        m   = 65536;
        sat = 1'b0;
        for (int k = 1; k <= 8; k++)
            if (f[8-k]) m = (m * ck(k)) >> 16;
        sh = ip + 8 - 16;
        if (lg == 17'h10000) mag = 0;
        else if (sh >= 0) begin
            if (sh > 40) begin mag = MAXM; sat = 1'b1; end
            else begin
                mag = m << sh;
                if (mag > MAXM) begin mag = MAXM; sat = 1'b1; end
            end
        end else if (-sh >= 18) mag = 0;
        else mag = m >> (-sh);
        lin = sgn ? 32'(mag) : 32'(-mag);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (oe_force) data_out_enable = oe_val;
        else          data_out_enable = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive_word(input logic [16:0] lg, input bit sgn, input bit hg,
                              input longint gold, input int tol, output int waited);
        exp_t e;
        model(lg, sgn, e.lin, e.sat);
        e.hg = hg; e.gold = gold; e.tol = tol; e.lg = lg;
        data_in_log = lg; data_in_nat_sign = sgn; data_in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (data_in_enable) begin
                e.acc = cyc + 1;
                sb.push_back(e);
                n_vec++;
                waited = t;
                tick();
                data_in_valid = 1'b0;
                return;
            end
            tick();
        end
        waited = 200;
        n_chk++; n_bad++;
        $display("FAIL accept_timeout: log %h not accepted in 200 cycles", lg);
        data_in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 400; t++) begin
            if (sb.size() == 0) return;
            tick();
        end
        n_chk++; n_bad++;
        $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    endtask

    always @(negedge clk) begin
        if (rst) prev_valid = 1'b0;
        else begin
            if (data_out_valid) begin
                check("in_enable_in_out", longint'(data_in_enable), longint'(data_out_enable));
                if (prev_valid && !prev_oe) begin
                    check("hold_lin", longint'($signed(data_out_lin)), longint'($signed(prev_lin)));
                    check("hold_sat", longint'(data_out_sat), longint'(prev_sat));
                end
                if (sb.size() == 0) begin
                    n_chk++; n_bad++;
                    $display("FAIL unexpected_output: got %0d, expected no result", $signed(data_out_lin));
                end else begin
                    if (!prev_valid) check("latency", longint'(cyc - sb[0].acc), LAT);
                    if (data_out_enable) begin
                        mon_e = sb.pop_front();
                        check("lin", longint'($signed(data_out_lin)), longint'($signed(mon_e.lin)));
                        check("sat", longint'(data_out_sat), longint'(mon_e.sat));
                        if (mon_e.hg) begin
                            mon_d = longint'($signed(data_out_lin)) - mon_e.gold;
                            if (mon_d < 0) mon_d = -mon_d;
                            n_chk++;
                            if (mon_d > mon_e.tol) begin
                                n_bad++;
                                $display("FAIL gold log=%h: got %0d, expected %0d +/- %0d",
                                         mon_e.lg, $signed(data_out_lin), mon_e.gold, mon_e.tol);
                            end
                        end
                    end
                end
            end
            prev_valid = data_out_valid;
            prev_oe    = data_out_enable;
            prev_lin   = data_out_lin;
            prev_sat   = data_out_sat;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [16:0] lg;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", longint'(data_out_valid), 0);
        check("rst_lin", longint'(data_out_lin), 0);
        check("rst_sat", longint'(data_out_sat), 0);
        check("rst_in_enable", longint'(data_in_enable), 1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < ND; i++) begin
            drive_word(d_lg[i], d_sg[i], 1'b1, d_gold[i], d_tol[i], w);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();

        // Backpressure: hold result 5 cycles with a word waiting, then release.
        oe_force = 1'b1; oe_val = 1'b0; data_out_enable = 1'b0;
        drive_word(17'h00300, 1'b1, 1'b1, 2048, 0, w);
        for (int t = 0; t < 40 && !data_out_valid; t++) tick();
        check("bp_result_present", longint'(data_out_valid), 1);
        data_in_log = 17'h00080; data_in_nat_sign = 1'b1; data_in_valid = 1'b1;
        repeat (5) begin
            tick();
            check("bp_in_enable", longint'(data_in_enable), 0);
        end
        oe_val = 1'b1; data_out_enable = 1'b1;
        drive_word(17'h00080, 1'b1, 1'b1, 362, 1, w);
        check("bp_same_edge_accept", w, 0);
        oe_force = 1'b0;
        drain();

        // Reset during EXP discards the word; the next one decodes normally.
        drive_word(17'h00300, 1'b1, 1'b0, 0, 0, w);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("midrst_valid", longint'(data_out_valid), 0);
        check("midrst_in_enable", longint'(data_in_enable), 1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_word(17'h1FF00, 1'b0, 1'b1, -128, 0, w);
        drain();

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) lg = 17'($urandom);
            else lg = 17'((int'($urandom_range(0, 55)) - 25) * 256 + int'($urandom_range(0, 255)));
            drive_word(lg, 1'($urandom_range(0, 1)), 1'b0, 0, 0, w);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        check("scoreboard_empty", longint'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
